// File: rtl/keypad_scan_ev.sv
`timescale 1ns/1ps
// keypad_scan_ev: matrix keypad scanner with per-key debounce, typematic
// auto-repeat and a valid/ready event output (press / repeat / release).
module keypad_scan_ev #(
   parameter int unsigned ROWS          = 4,
   parameter int unsigned COLS          = 4,
   parameter int unsigned SCAN_DIV      = 16,
   parameter int unsigned DEBOUNCE      = 4000,
   parameter int unsigned REPEAT_DELAY  = 0,
   parameter int unsigned REPEAT_PERIOD = 0,
   localparam int unsigned KW           = $clog2(ROWS * COLS)
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [COLS-1:0] C,
   output logic [ROWS-1:0] R,
   output logic            ev_valid,
   input  logic            ev_ready,
   output logic [KW-1:0]   ev_code,
   output logic [1:0]      ev_kind,
   output logic            key_held,
   output logic            ev_drop
);

   localparam int unsigned RW   = $clog2(ROWS);
   localparam int unsigned CW   = $clog2(COLS);
   localparam int unsigned DW   = $clog2(SCAN_DIV);
   localparam int unsigned BW   = $clog2(DEBOUNCE);
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned PW   = (RMAX < 2) ? 1 : $clog2(RMAX);

   localparam logic [1:0] SCAN     = 2'd0;
   localparam logic [1:0] PRESS_DB = 2'd1;
   localparam logic [1:0] HELD     = 2'd2;
   localparam logic [1:0] REL_DB   = 2'd3;

   localparam logic [1:0] EV_PRESS   = 2'd0;
   localparam logic [1:0] EV_REPEAT  = 2'd1;
   localparam logic [1:0] EV_RELEASE = 2'd2;

   localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE - 1);
   localparam logic [PW-1:0] REP_FIRST  = (REPEAT_DELAY == 0)  ? '0 : PW'(REPEAT_DELAY - 1);
   localparam logic [PW-1:0] REP_NEXT   = (REPEAT_PERIOD == 0) ? '0 : PW'(REPEAT_PERIOD - 1);

   logic [COLS-1:0] c_m, c_s;
   logic [1:0]      state, state_n;
   logic [RW-1:0]   row, row_n, row_inc;
   logic [CW-1:0]   col, col_n, col_first;
   logic            any_low;
   logic [DW-1:0]   dwell, dwell_n;
   logic [BW-1:0]   db, db_n;
   logic [PW-1:0]   rep, rep_n;
   logic            rep_first, rep_first_n;
   logic            run;
   logic            ev_new;
   logic [1:0]      new_kind;
   logic [KW-1:0]   new_code;
   logic            col_up;

   assign row_inc  = (row == ROW_LAST) ? '0 : row + 1'b1;
   assign col_up   = c_s[col];
   assign new_code = KW'(32'(row) * COLS + 32'(col));
   assign key_held = (state == HELD) || (state == REL_DB);

   // Two-flop synchroniser for the asynchronous column returns (idle high).
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         c_m <= '1;
         c_s <= '1;
      end else begin
         c_m <= C;
         c_s <= c_m;
      end
   end

   // Lowest-index active column of the synchronised returns.
   always_comb begin
      col_first = '0;
      any_low   = 1'b0;
      for (int unsigned i = 0; i < COLS; i++) begin
         if (!c_s[i] && !any_low) begin
            col_first = CW'(i);
            any_low   = 1'b1;
         end
      end
   end

   // Row strobe: released during reset, then the current row is driven low.
   always_comb begin
      R = run ? ~(ROWS'(1) << row) : '1;
   end

   // Scan / debounce / repeat state machine: next-state and event requests.
   always_comb begin
      state_n     = state;
      row_n       = row;
      col_n       = col;
      dwell_n     = dwell;
      db_n        = db;
      rep_n       = rep;
      rep_first_n = rep_first;
      ev_new      = 1'b0;
      new_kind    = EV_PRESS;
      case (state)
         SCAN: begin
            if (run) begin
               if (dwell == DWELL_LAST) begin
                  dwell_n = '0;
                  if (any_low) begin
                     state_n = PRESS_DB;
                     col_n   = col_first;
                     db_n    = '0;
                  end else begin
                     row_n = row_inc;
                  end
               end else begin
                  dwell_n = dwell + 1'b1;
               end
            end
         end
         PRESS_DB: begin
            if (col_up) begin
               state_n = SCAN;
               row_n   = row_inc;
               dwell_n = '0;
            end else if (db == DB_LAST) begin
               ev_new      = 1'b1;
               new_kind    = EV_PRESS;
               state_n     = HELD;
               rep_n       = '0;
               rep_first_n = 1'b0;
            end else begin
               db_n = db + 1'b1;
            end
         end
         HELD: begin
            if (col_up) begin
               state_n = REL_DB;
               db_n    = '0;
            end
            // The repeat counter also advances on the cycle that starts a
            // release check, so only cycles spent in REL_DB delay a repeat.
            if (REPEAT_DELAY != 0) begin
               if (rep == (rep_first ? REP_NEXT : REP_FIRST)) begin
                  ev_new      = 1'b1;
                  new_kind    = EV_REPEAT;
                  rep_n       = '0;
                  rep_first_n = 1'b1;
               end else begin
                  rep_n = rep + 1'b1;
               end
            end
         end
         REL_DB: begin
            if (!col_up) begin
               state_n = HELD;
            end else if (db == DB_LAST) begin
               ev_new   = 1'b1;
               new_kind = EV_RELEASE;
               state_n  = SCAN;
               row_n    = row_inc;
               dwell_n  = '0;
            end else begin
               db_n = db + 1'b1;
            end
         end
         default: state_n = SCAN;
      endcase
   end

   // State machine registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= SCAN;
         row       <= '0;
         col       <= '0;
         dwell     <= '0;
         db        <= '0;
         rep       <= '0;
         rep_first <= 1'b0;
         run       <= 1'b0;
      end else begin
         state     <= state_n;
         row       <= row_n;
         col       <= col_n;
         dwell     <= dwell_n;
         db        <= db_n;
         rep       <= rep_n;
         rep_first <= rep_first_n;
         run       <= 1'b1;
      end
   end

   // Output event register: load when free or being accepted, else drop.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ev_valid <= 1'b0;
         ev_code  <= '0;
         ev_kind  <= '0;
         ev_drop  <= 1'b0;
      end else begin
         ev_drop <= 1'b0;
         if (ev_new) begin
            if (ev_valid && !ev_ready) begin
               ev_drop <= 1'b1;
            end else begin
               ev_valid <= 1'b1;
               ev_code  <= new_code;
               ev_kind  <= new_kind;
            end
         end else if (ev_ready) begin
            ev_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan_ev.sv
`timescale 1ns/1ps
// tb_keypad_scan_ev: two scanner instances (repeat off / repeat 40,10) driven
// from a keypad-matrix model; events are checked against timing rules.
module tb_keypad_scan_ev;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int SD   = 4;
   localparam int DEB  = 8;
   localparam int RD   = 40;
   localparam int RP   = 10;

   typedef struct { int code; int kind; int t; } ev_t;
   typedef struct { logic [15:0] mask; int code; int hold; } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [3:0]  c0, c1, r0, r1;
   logic        v0, v1, rdy0, rdy1;
   logic [3:0]  code0, code1;
   logic [1:0]  kind0, kind1;
   logic        held0, held1, drop0, drop1;
   logic [15:0] keys0, keys1;

   int   cyc = 0;
   int   drops0 = 0;
   int   drops1 = 0;
   int   errors = 0;
   int   checks = 0;
   ev_t  q0[$];
   ev_t  q1[$];

   keypad_scan_ev #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE(DEB),
                    .REPEAT_DELAY(0), .REPEAT_PERIOD(0)) u0 (
      .CLK(clk), .RST_N(rst_n), .C(c0), .R(r0), .ev_valid(v0), .ev_ready(rdy0),
      .ev_code(code0), .ev_kind(kind0), .key_held(held0), .ev_drop(drop0));

   keypad_scan_ev #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE(DEB),
                    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u1 (
      .CLK(clk), .RST_N(rst_n), .C(c1), .R(r1), .ev_valid(v1), .ev_ready(rdy1),
      .ev_code(code1), .ev_kind(kind1), .key_held(held1), .ev_drop(drop1));

   // Keypad matrix: a pressed key pulls its column low while its row is driven.
   always_comb begin
      c0 = '1;
      c1 = '1;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (keys0[r*COLS+c] && !r0[r]) c0[c] = 1'b0;
            if (keys1[r*COLS+c] && !r1[r]) c1[c] = 1'b0;
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Consumer-side monitor: record every accepted event with its cycle.
   always @(negedge clk) begin
      if (v0 && rdy0) q0.push_back('{code: int'(code0), kind: int'(kind0), t: cyc});
      if (v1 && rdy1) q1.push_back('{code: int'(code1), kind: int'(kind1), t: cyc});
      if (drop0) drops0 <= drops0 + 1;
      if (drop1) drops1 <= drops1 + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_rng(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic wait_q(input int which, input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if ((which == 0 ? q0.size() : q1.size()) >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   function automatic ev_t pop_ev(input int which);
      ev_t e;
      e = '{code: -1, kind: -1, t: -1};
      if (which == 0) begin
         if (q0.size() > 0) e = q0.pop_front();
      end else if (q1.size() > 0) begin
         e = q1.pop_front();
      end
      return e;
   endfunction

   // Repeat-off instance: press a key pattern, hold, release, expect press+release.
   task automatic press_release0(input logic [15:0] mask, input int code, input int hold, input string tag);
      bit  ok;
      ev_t e;
      int  tp, te, trel;
      keys0 = mask;
      tp = cyc;
      wait_q(0, 1, 60, ok);
      check({tag, "_press_seen"}, int'(ok), 1);
      e = pop_ev(0);
      check({tag, "_press_code"}, e.code, code);
      check({tag, "_press_kind"}, e.kind, 0);
      check_rng({tag, "_press_lat"}, e.t - tp, DEB + 3, DEB + 3 + ROWS*SD + 4);
      check({tag, "_held"}, int'(held0), 1);
      te = e.t;
      while (cyc < te + hold) @(negedge clk);
      keys0 = '0;
      trel = cyc;
      wait_q(0, 1, 40, ok);
      check({tag, "_rel_seen"}, int'(ok), 1);
      e = pop_ev(0);
      check({tag, "_rel_code"}, e.code, code);
      check({tag, "_rel_kind"}, e.kind, 2);
      check_rng({tag, "_rel_lat"}, e.t - trel, DEB + 2, DEB + 3);
      check({tag, "_released"}, int'(held0), 0);
      repeat (20) @(negedge clk);
      check({tag, "_no_extra"}, q0.size(), 0);
      q0.delete();
   endtask

   // Repeat-on instance: hold key k for h cycles after its press event.
   // Repeats must land exactly RD, RD+RP, ... after the press.
   task automatic hold_key1(input int k, input int h, input int nrep, input string tag);
      bit  ok;
      ev_t e;
      int  tp, te, trel;
      keys1[k] = 1'b1;
      tp = cyc;
      wait_q(1, 1, 60, ok);
      check({tag, "_press_seen"}, int'(ok), 1);
      e = pop_ev(1);
      check({tag, "_press_code"}, e.code, k);
      check({tag, "_press_kind"}, e.kind, 0);
      check_rng({tag, "_press_lat"}, e.t - tp, DEB + 3, DEB + 3 + ROWS*SD + 4);
      te = e.t;
      while (cyc < te + h) @(negedge clk);
      keys1[k] = 1'b0;
      trel = cyc;
      repeat (30) @(negedge clk);
      #1;
      check({tag, "_event_count"}, q1.size(), nrep + 1);
      for (int i = 0; i < nrep; i++) begin
         e = pop_ev(1);
         check({tag, "_rep_kind"}, e.kind, 1);
         check({tag, "_rep_code"}, e.code, k);
         check({tag, "_rep_time"}, e.t - te, RD + i*RP);
      end
      e = pop_ev(1);
      check({tag, "_rel_kind"}, e.kind, 2);
      check({tag, "_rel_code"}, e.code, k);
      check_rng({tag, "_rel_lat"}, e.t - trel, DEB + 2, DEB + 3);
      q1.delete();
   endtask

   initial begin
      vec_t       vec[6];
      bit         ok;
      ev_t        e;
      logic [3:0] exp_r, r_a;
      int         bad, base, k, h, n, nrep;

      vec[0] = '{mask: 16'h0001, code: 0,  hold: 20};
      vec[1] = '{mask: 16'h0200, code: 9,  hold: 90};
      vec[2] = '{mask: 16'h8000, code: 15, hold: 30};
      vec[3] = '{mask: 16'h5000, code: 12, hold: 25};
      vec[4] = '{mask: 16'h00C0, code: 6,  hold: 15};
      vec[5] = '{mask: 16'h0008, code: 3,  hold: 10};

      rst_n = 1'b0;
      keys0 = '0;
      keys1 = '0;
      rdy0  = 1'b1;
      rdy1  = 1'b1;
      repeat (3) @(negedge clk);

      check("rst_R0", int'(r0), 15);
      check("rst_R1", int'(r1), 15);
      check("rst_valid", int'(v0), 0);
      check("rst_code", int'(code0), 0);
      check("rst_kind", int'(kind0), 0);
      check("rst_held", int'(held0), 0);
      check("rst_drop", int'(drop0), 0);

      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 2*ROWS*SD; i++) begin
         @(negedge clk);
         exp_r = ~(4'b0001 << ((i / SD) % ROWS));
         if (i == 0) check("first_edge_row0", int'(r0), int'(exp_r));
         if (r0 !== exp_r || r1 !== exp_r) bad++;
      end
      check("scan_sweep", bad, 0);

      // Auto-repeat: press code 5, hold 95 cycles past the press event.
      hold_key1(5, 95, 6, "autorep");
      repeat (10) @(negedge clk);

      // Randomised holds kept clear of repeat boundaries.
      for (int it = 0; it < 10; it++) begin
         k = $urandom_range(15, 0);
         if ($urandom_range(3, 0) == 0) begin
            h    = $urandom_range(RD - 5, 5);
            nrep = 0;
         end else begin
            n    = $urandom_range(3, 0);
            h    = RD + n*RP + $urandom_range(RP - 4, 4);
            nrep = n + 1;
         end
         hold_key1(k, h, nrep, "rand");
         repeat ($urandom_range(20, 1)) @(negedge clk);
      end

      // Table of single-press patterns on the repeat-off instance.
      for (int i = 0; i < 6; i++) begin
         press_release0(vec[i].mask, vec[i].code, vec[i].hold, "table");
      end

      // Bounce rejection: 5 low / 1 high on key 0 never qualifies.
      for (int i = 0; i < 20; i++) begin
         keys0[0] = 1'b1;
         repeat (5) @(negedge clk);
         keys0[0] = 1'b0;
         @(negedge clk);
      end
      repeat (10) @(negedge clk);
      #1;
      check("bounce_no_event", q0.size(), 0);
      r_a = r0;
      repeat (8) @(negedge clk);
      check("bounce_scan_moves", int'(r0 != r_a), 1);
      press_release0(16'h0001, 0, 15, "bounce_hold");

      // Two keys in row 1: col 0 wins, then col 2 after col 0 lifts.
      keys0 = 16'h0050;
      wait_q(0, 1, 60, ok);
      check("two_press_seen", int'(ok), 1);
      e = pop_ev(0);
      check("two_first_code", e.code, 4);
      check("two_first_kind", e.kind, 0);
      repeat (10) @(negedge clk);
      keys0 = 16'h0040;
      wait_q(0, 2, 80, ok);
      check("two_events_seen", int'(ok), 1);
      e = pop_ev(0);
      check("two_rel_code", e.code, 4);
      check("two_rel_kind", e.kind, 2);
      e = pop_ev(0);
      check("two_second_code", e.code, 6);
      check("two_second_kind", e.kind, 0);
      keys0 = '0;
      wait_q(0, 1, 40, ok);
      e = pop_ev(0);
      check("two_rel2_code", e.code, 6);
      check("two_rel2_kind", e.kind, 2);
      repeat (10) @(negedge clk);
      q0.delete();

      // Back-pressure: press held in the output, release dropped.
      rdy0 = 1'b0;
      base = drops0;
      keys0[3] = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         ok = v0;
      end
      check("bp_valid_seen", int'(ok), 1);
      repeat (20) @(negedge clk);
      keys0[3] = 1'b0;
      repeat (30) @(negedge clk);
      check("bp_valid_kept", int'(v0), 1);
      check("bp_code_kept", int'(code0), 3);
      check("bp_kind_kept", int'(kind0), 0);
      check("bp_drop_pulses", drops0 - base, 1);
      check("bp_released", int'(held0), 0);
      @(posedge clk);
      #1 rdy0 = 1'b1;
      @(posedge clk);
      #1;
      check("bp_valid_cleared", int'(v0), 0);
      e = pop_ev(0);
      check("bp_accepted_code", e.code, 3);
      check("bp_queue_empty", q0.size(), 0);
      repeat (10) @(negedge clk);
      q0.delete();

      // Reset while a key is held: no release, then a fresh press.
      keys0[5] = 1'b1;
      wait_q(0, 1, 60, ok);
      e = pop_ev(0);
      check("rh_press_code", e.code, 5);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rh_valid", int'(v0), 0);
      check("rh_held", int'(held0), 0);
      check("rh_R", int'(r0), 15);
      check("rh_code", int'(code0), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_q(0, 1, 60, ok);
      check("rh_repress_seen", int'(ok), 1);
      e = pop_ev(0);
      check("rh_repress_kind", e.kind, 0);
      check("rh_repress_code", e.code, 5);
      keys0[5] = 1'b0;
      wait_q(0, 1, 40, ok);
      e = pop_ev(0);
      check("rh_rel_kind", e.kind, 2);
      check("rh_rel_code", e.code, 5);

      repeat (10) @(negedge clk);
      check("u1_quiet", q1.size(), 0);
      check("u1_no_drops", drops1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/keypad_scan_ev.md
# keypad_scan_ev

Parametrised matrix-keypad scanner with per-key debounce, typematic auto-repeat and a valid/ready event output. It drives an active-low row strobe, reads active-low column returns, and reports one event per press, per repeat and per release. It replaces the fixed 4x4 scanner in the phone front end, and feeds the number/command decoder through a handshake rather than a clock derived from a pulse.

## Interface
- ROWS, 4: number of row lines, 2..8
- COLS, 4: number of column lines, 2..8
- SCAN_DIV, 16: cycles each row is driven before its columns are sampled, at least 2
- DEBOUNCE, 4000: consecutive stable cycles required to accept a press or a release, at least 2
- REPEAT_DELAY, 0: cycles of hold before the first repeat event; 0 disables auto-repeat
- REPEAT_PERIOD, 0: cycles between later repeat events; must be at least 1 when REPEAT_DELAY is nonzero
- CLK  in  1  system clock, all state changes on the rising edge
- RST_N  in  1  asynchronous active-low reset
- C  in  COLS  column returns, active-low, asynchronous to CLK, passed through a 2-flop synchroniser
- R  out  ROWS  row drive, active-low, one-hot-low while scanning
- ev_valid  out  1  event available
- ev_ready  in  1  consumer accepts event
- ev_code  out  KW  key index = row*COLS+col, where KW = clog2(ROWS*COLS)
- ev_kind  out  2  event type: 0 = press, 1 = repeat, 2 = release
- key_held  out  1  a debounced key is currently down
- ev_drop  out  1  one-cycle pulse when an event is lost because the output is occupied

## Operation
- Every reference to C below means the synchronised value.
- State machine states: SCAN, PRESS_DB, HELD, REL_DB.
- **SCAN**
  - R = ~(1<<row).
  - The dwell counter counts 0..SCAN_DIV-1.
  - On the last dwell cycle C is sampled. If any bit is low, latch col = lowest-index low bit and go to PRESS_DB.
  - Otherwise advance row, wrapping from ROWS-1 to 0, and clear the dwell counter.
- **PRESS_DB**
  - R stays fixed on the latched row.
  - While C[col]=0 the debounce counter increments. When it reaches DEBOUNCE-1 with C[col]=0: emit a press event, go to HELD, clear the repeat counter.
  - Any cycle with C[col]=1: return to SCAN, advance row, emit nothing.
- **HELD**
  - R stays fixed and key_held=1.
  - C[col]=1: go to REL_DB with the debounce counter at 0.
  - When REPEAT_DELAY≠0 the repeat counter runs. The first repeat event is emitted when it reaches REPEAT_DELAY-1; after that one is emitted every REPEAT_PERIOD cycles.
- **REL_DB**
  - key_held stays 1.
  - C[col]=1 for DEBOUNCE consecutive cycles: emit a release event, key_held=0, return to SCAN and advance row.
  - Any C[col]=0: return to HELD. The repeat counter is not reset and is frozen while in REL_DB.
- Other keys in the same row, and other rows, are ignored while a key is latched. There is no ghost-key filtering.
- **Event register**
  - A new event loads ev_code/ev_kind and sets ev_valid.
  - If ev_valid=1 and ev_ready=0 when a new event arrives, the new event is discarded and ev_drop pulses for one cycle. The held event is unchanged.
  - If ev_valid=1 and ev_ready=1 in the same cycle as a new event, the new event is loaded: accept and load happen together, with no drop.
- Counter widths are clog2 of their maximum values. Counters saturate and never wrap.

## Timing
- Reset values: R = all ones, ev_valid=0, ev_code=0, ev_kind=0, key_held=0, ev_drop=0, state=SCAN, row=0, all counters 0.
- On the first edge after RST_N deasserts, R drives row 0 low.
- Reset asserted mid-press or mid-event discards everything. No release event is emitted for a key held across reset.
- Column sample: at edge t, C[col]=0 seen at the end of dwell. State becomes PRESS_DB.
- Press latency: with stable contact, ev_valid rises after edge t+DEBOUNCE. Add 2 cycles for the synchroniser, measured from the pin.
- ev_valid stays high until the edge on which ev_ready=1; it falls on that edge unless a new event loads in the same cycle.
- Full scan period with no keys: ROWS*SCAN_DIV cycles.
- Repeat timing: with DELAY=D and PERIOD=P, repeats arrive D, D+P, D+2P… cycles after the press event, plus any time spent in REL_DB bounces.
- Release latency: DEBOUNCE cycles of continuous release after the synchroniser.

## Test plan
- **Single press.** Setup: ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE=8, repeat off, ev_ready=1. Stimulus: hold row2/col1 low for 100 cycles. Response: one press with ev_code=9, then one release with ev_code=9 and ev_kind=2. key_held is high between them.
- **Bounce rejection.** Stimulus: toggle C[0] low 5 cycles, high 1, repeated. Response: no event, scanning continues. Then hold low for 8+ cycles: exactly one press event.
- **Auto-repeat.** Setup: REPEAT_DELAY=40, REPEAT_PERIOD=10. Stimulus: hold key code 5 for 100 cycles. Response: press, then repeats at +40, +50, +60, +70, +80, +90 after the press event, then release.
- **Back-pressure.** Setup: ev_ready=0. Stimulus: press and release code 3. Response: press stays held in the output, release is dropped with a one-cycle ev_drop. Raising ev_ready clears ev_valid.
- **Two keys in one row.** Stimulus: row1 cols 0 and 2 low together. Response: ev_code=4 only. Releasing col 0 while col 2 stays low gives release code 4; the scan then resumes and reports code 6.
- **Reset mid-hold.** Stimulus: pull RST_N low while in HELD. Response: all outputs return to reset values immediately and no release event follows. After reset the still-held key produces a fresh press.
